// File: rtl/avalon_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | avalon_bus_arbiter: two-master / one-slave Avalon-MM bus arbiter.  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module avalon_bus_arbiter #(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int ROUND_ROBIN = 0,
  parameter  int MAX_HOLD    = 4,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int HC_W = $clog2(MAX_HOLD) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic              last_q, last_d;

  logic              req0, req1;
  logic              own_req, oth_req, oth_idx;
  state_t            oth_state;
  logic [HC_W:0]     hold_next;
  logic              hold_hit;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign hold_next = {1'b0, hold_cnt_q} + (HC_W+1)'(1);
  assign hold_hit  = hold_next >= (HC_W+1)'(MAX_HOLD);

  always_comb begin
    own_req    = (state_q == GNT1) ? req1 : req0;
    oth_req    = (state_q == GNT1) ? req0 : req1;
    oth_state  = (state_q == GNT1) ? GNT0 : GNT1;
    oth_idx    = (state_q == GNT0);
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    unique case (state_q)
      IDLE: begin
        // On a tie m0 wins unless round-robin says m0 went last.
        if (req0 && (!req1 || ROUND_ROBIN == 0 || last_q)) begin
          state_d    = GNT0;
          hold_cnt_d = '0;
          last_d     = 1'b0;
        end else if (req1) begin
          state_d    = GNT1;
          hold_cnt_d = '0;
          last_d     = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!own_req) begin
          hold_cnt_d = '0;
          if (oth_req) begin
            state_d = oth_state;
            last_d  = oth_idx;
          end else begin
            state_d = IDLE;
          end
        end else if (!s_waitrequest) begin
          if (oth_req && hold_hit) begin
            state_d    = oth_state;
            hold_cnt_d = '0;
            last_d     = oth_idx;
          end else if (oth_req) begin
            hold_cnt_d = hold_next[HC_W-1:0];
          end
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
    grant_d = {state_d == GNT1, state_d == GNT0};
    busy_d  = |grant_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
    end
  end

  // Slave side decodes from state only, so reset kills the strobes at once.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (state_q == GNT0) begin
      s_address      = m0_address;
      s_read         = m0_read;
      s_write        = m0_write;
      s_writedata    = m0_writedata;
      s_byteenable   = m0_byteenable;
      m0_waitrequest = s_waitrequest;
    end else if (state_q == GNT1) begin
      s_address      = m1_address;
      s_read         = m1_read;
      s_write        = m1_write;
      s_writedata    = m1_writedata;
      s_byteenable   = m1_byteenable;
      m1_waitrequest = s_waitrequest;
    end
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign grant       = grant_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_bus_arbiter.sv
`default_nettype none
// Directed bench for avalon_bus_arbiter: instance A is fixed priority with
// MAX_HOLD=4 and a small RAM model; instance B is round-robin with MAX_HOLD=1.
module tb_avalon_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        a_rst;
  logic [31:0] a_m0_address, a_m0_writedata, a_m0_readdata;
  logic        a_m0_read, a_m0_write, a_m0_waitrequest;
  logic [3:0]  a_m0_byteenable;
  logic [31:0] a_m1_address, a_m1_writedata, a_m1_readdata;
  logic        a_m1_read, a_m1_write, a_m1_waitrequest;
  logic [3:0]  a_m1_byteenable;
  logic [31:0] a_s_address, a_s_writedata, a_s_readdata;
  logic        a_s_read, a_s_write, a_s_waitrequest;
  logic [3:0]  a_s_byteenable;
  logic [1:0]  a_grant;
  logic        a_busy;

  logic        b_rst;
  logic [31:0] b_m0_address, b_m0_writedata, b_m0_readdata;
  logic        b_m0_read, b_m0_write, b_m0_waitrequest;
  logic [3:0]  b_m0_byteenable;
  logic [31:0] b_m1_address, b_m1_writedata, b_m1_readdata;
  logic        b_m1_read, b_m1_write, b_m1_waitrequest;
  logic [3:0]  b_m1_byteenable;
  logic [31:0] b_s_address, b_s_writedata, b_s_readdata;
  logic        b_s_read, b_s_write, b_s_waitrequest;
  logic [3:0]  b_s_byteenable;
  logic [1:0]  b_grant;
  logic        b_busy;

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0), .MAX_HOLD(4)) dut_a (
    .clk(clk), .reset(a_rst),
    .m0_address(a_m0_address), .m0_read(a_m0_read), .m0_write(a_m0_write),
    .m0_writedata(a_m0_writedata), .m0_byteenable(a_m0_byteenable),
    .m0_waitrequest(a_m0_waitrequest), .m0_readdata(a_m0_readdata),
    .m1_address(a_m1_address), .m1_read(a_m1_read), .m1_write(a_m1_write),
    .m1_writedata(a_m1_writedata), .m1_byteenable(a_m1_byteenable),
    .m1_waitrequest(a_m1_waitrequest), .m1_readdata(a_m1_readdata),
    .s_address(a_s_address), .s_read(a_s_read), .s_write(a_s_write),
    .s_writedata(a_s_writedata), .s_byteenable(a_s_byteenable),
    .s_waitrequest(a_s_waitrequest), .s_readdata(a_s_readdata),
    .grant(a_grant), .busy(a_busy)
  );

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1), .MAX_HOLD(1)) dut_b (
    .clk(clk), .reset(b_rst),
    .m0_address(b_m0_address), .m0_read(b_m0_read), .m0_write(b_m0_write),
    .m0_writedata(b_m0_writedata), .m0_byteenable(b_m0_byteenable),
    .m0_waitrequest(b_m0_waitrequest), .m0_readdata(b_m0_readdata),
    .m1_address(b_m1_address), .m1_read(b_m1_read), .m1_write(b_m1_write),
    .m1_writedata(b_m1_writedata), .m1_byteenable(b_m1_byteenable),
    .m1_waitrequest(b_m1_waitrequest), .m1_readdata(b_m1_readdata),
    .s_address(b_s_address), .s_read(b_s_read), .s_write(b_s_write),
    .s_writedata(b_s_writedata), .s_byteenable(b_s_byteenable),
    .s_waitrequest(b_s_waitrequest), .s_readdata(b_s_readdata),
    .grant(b_grant), .busy(b_busy)
  );

  // RAM model behind instance A; preload goes through the same write port.
  logic [31:0] mem_a [0:15];
  logic        a_stall, pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_dat;
  assign a_s_waitrequest = a_stall;
  assign a_s_readdata    = mem_a[a_s_address[5:2]];
  always @(posedge clk) begin
    if (pl_en) mem_a[pl_idx] <= pl_dat;
    else if (a_s_write && !a_s_waitrequest) mem_a[a_s_address[5:2]] <= a_s_writedata;
  end

  logic b_stall;
  assign b_s_waitrequest = b_stall;
  assign b_s_readdata    = {16'hB0B0, b_s_address[15:0]};

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] dat);
    pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; a_m1_read = 1'b1; a_m1_address = 32'h08;
    preload(4'd2, 32'h24020010);
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b00) begin n_bad++; $display("FAIL rst_grant: got %b want 00", a_grant); end
    n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    n_cmp++; if (a_s_read !== 1'b0) begin n_bad++; $display("FAIL rst_s_read: got %b want 0", a_s_read); end
    n_cmp++; if (a_m1_waitrequest !== 1'b1) begin n_bad++; $display("FAIL rst_m1_wait: got %b want 1", a_m1_waitrequest); end
    a_rst = 1'b0;
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b10) begin n_bad++; $display("FAIL rel_grant: got %b want 10", a_grant); end
    n_cmp++; if (a_s_address !== 32'h08) begin n_bad++; $display("FAIL rel_s_addr: got %h want 00000008", a_s_address); end
    n_cmp++; if (a_m1_waitrequest !== 1'b0) begin n_bad++; $display("FAIL rel_m1_wait: got %b want 0", a_m1_waitrequest); end
    n_cmp++; if (a_m1_readdata !== 32'h24020010) begin n_bad++; $display("FAIL rel_rdata: got %h want 24020010", a_m1_readdata); end
    cyc();
    a_m1_read = 1'b0;
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b00) begin n_bad++; $display("FAIL rel_idle: got %b want 00", a_grant); end
  endtask

  task automatic test_fixed_priority();
    a_m0_write = 1'b1; a_m0_address = 32'h04; a_m0_writedata = 32'h2403FFFB; a_m0_byteenable = 4'hF;
    a_m1_read = 1'b1; a_m1_address = 32'h04;
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b01) begin n_bad++; $display("FAIL fp_grant0: got %b want 01", a_grant); end
    n_cmp++; if (a_s_write !== 1'b1) begin n_bad++; $display("FAIL fp_s_write: got %b want 1", a_s_write); end
    n_cmp++; if (a_s_writedata !== 32'h2403FFFB) begin n_bad++; $display("FAIL fp_s_wdata: got %h want 2403fffb", a_s_writedata); end
    n_cmp++; if (a_m1_waitrequest !== 1'b1) begin n_bad++; $display("FAIL fp_m1_wait: got %b want 1", a_m1_waitrequest); end
    cyc();
    a_m0_write = 1'b0;
    #1;
    n_cmp++; if (a_grant !== 2'b01) begin n_bad++; $display("FAIL fp_grant_hold: got %b want 01", a_grant); end
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b10) begin n_bad++; $display("FAIL fp_grant1: got %b want 10", a_grant); end
    n_cmp++; if (a_m1_readdata !== 32'h2403FFFB) begin n_bad++; $display("FAIL fp_rdata: got %h want 2403fffb", a_m1_readdata); end
    n_cmp++; if (a_m0_waitrequest !== 1'b1) begin n_bad++; $display("FAIL fp_m0_wait: got %b want 1", a_m0_waitrequest); end
    cyc();
    a_m1_read = 1'b0;
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b00) begin n_bad++; $display("FAIL fp_idle: got %b want 00", a_grant); end
  endtask

  task automatic test_slave_stall();
    preload(4'd3, 32'h18600002);
    a_stall = 1'b1; a_m1_read = 1'b1; a_m1_address = 32'h0C;
    cyc();
    a_m0_write = 1'b1; a_m0_address = 32'h20; a_m0_writedata = 32'hDEAD0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (a_grant !== 2'b10) begin n_bad++; $display("FAIL st_grant[%0d]: got %b want 10", i, a_grant); end
      n_cmp++; if (a_s_address !== 32'h0C) begin n_bad++; $display("FAIL st_addr[%0d]: got %h want 0000000c", i, a_s_address); end
      n_cmp++; if (a_m1_waitrequest !== 1'b1) begin n_bad++; $display("FAIL st_m1_wait[%0d]: got %b want 1", i, a_m1_waitrequest); end
      cyc();
    end
    a_stall = 1'b0;
    #1;
    n_cmp++; if (a_m1_readdata !== 32'h18600002) begin n_bad++; $display("FAIL st_rdata: got %h want 18600002", a_m1_readdata); end
    n_cmp++; if (a_m1_waitrequest !== 1'b0) begin n_bad++; $display("FAIL st_m1_done: got %b want 0", a_m1_waitrequest); end
    cyc();
    a_m1_read = 1'b0;
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b01) begin n_bad++; $display("FAIL st_handover: got %b want 01", a_grant); end
    cyc();
    a_m0_write = 1'b0;
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b00) begin n_bad++; $display("FAIL st_idle: got %b want 00", a_grant); end
  endtask

  task automatic test_hold_limit();
    int cnt;
    int guard;
    cnt = 0; guard = 0;
    a_m1_read = 1'b1; a_m1_address = 32'h10;
    a_m0_write = 1'b1; a_m0_address = 32'h04; a_m0_writedata = 32'hA0000001;
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b01) begin n_bad++; $display("FAIL hl_grant0: got %b want 01", a_grant); end
    while (a_grant == 2'b01 && guard < 12) begin
      if (!a_m0_waitrequest) begin
        cnt++;
        n_cmp++; if (a_m1_waitrequest !== 1'b1) begin n_bad++; $display("FAIL hl_m1_wait[%0d]: got %b want 1", cnt, a_m1_waitrequest); end
      end
      cyc();
      guard++;
      if (a_m0_address < 32'h1C) begin a_m0_address += 32'd4; a_m0_writedata += 32'd1; end
      #1;
    end
    n_cmp++; if (cnt !== 4) begin n_bad++; $display("FAIL hl_count: got %0d want 4", cnt); end
    n_cmp++; if (a_grant !== 2'b10) begin n_bad++; $display("FAIL hl_grant1: got %b want 10", a_grant); end
    n_cmp++; if (a_m1_readdata !== 32'hA0000004) begin n_bad++; $display("FAIL hl_rdata: got %h want a0000004", a_m1_readdata); end
    n_cmp++; if (a_m0_waitrequest !== 1'b1) begin n_bad++; $display("FAIL hl_m0_wait: got %b want 1", a_m0_waitrequest); end
    cyc();
    a_m1_read = 1'b0;
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b01) begin n_bad++; $display("FAIL hl_back0: got %b want 01", a_grant); end
    cyc();
    a_m0_write = 1'b0;
    cyc();
    #1;
    n_cmp++; if (a_grant !== 2'b00) begin n_bad++; $display("FAIL hl_idle: got %b want 00", a_grant); end
  endtask

  task automatic test_round_robin();
    int c0;
    int c1;
    logic [1:0] exp_g;
    c0 = 0; c1 = 0;
    b_m0_read = 1'b1; b_m0_address = 32'h40;
    b_m1_read = 1'b1; b_m1_address = 32'h80;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (b_grant !== exp_g) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, b_grant, exp_g); end
      n_cmp++; if (b_m0_waitrequest !== ~exp_g[0]) begin n_bad++; $display("FAIL rr_m0_wait[%0d]: got %b want %b", i, b_m0_waitrequest, ~exp_g[0]); end
      if (!b_m0_waitrequest) c0++;
      if (!b_m1_waitrequest) c1++;
    end
    n_cmp++; if (c0 !== 2) begin n_bad++; $display("FAIL rr_m0_count: got %0d want 2", c0); end
    n_cmp++; if (c1 !== 2) begin n_bad++; $display("FAIL rr_m1_count: got %0d want 2", c1); end
    b_m0_read = 1'b0; b_m1_read = 1'b0;
    cyc();
    #1;
    n_cmp++; if (b_grant !== 2'b00) begin n_bad++; $display("FAIL rr_idle: got %b want 00", b_grant); end
  endtask

  task automatic test_async_reset();
    b_stall = 1'b1;
    b_m0_write = 1'b1; b_m0_address = 32'h44; b_m0_writedata = 32'h5A5A5A5A; b_m0_byteenable = 4'hF;
    cyc();
    #1;
    n_cmp++; if (b_s_write !== 1'b1) begin n_bad++; $display("FAIL ar_s_write_pre: got %b want 1", b_s_write); end
    #2;
    b_rst = 1'b1;
    #1;
    n_cmp++; if (b_s_write !== 1'b0) begin n_bad++; $display("FAIL ar_s_write: got %b want 0", b_s_write); end
    n_cmp++; if (b_grant !== 2'b00) begin n_bad++; $display("FAIL ar_grant: got %b want 00", b_grant); end
    n_cmp++; if (b_m0_waitrequest !== 1'b1) begin n_bad++; $display("FAIL ar_m0_wait: got %b want 1", b_m0_waitrequest); end
    b_m1_read = 1'b1; b_m1_address = 32'h88;
    cyc();
    b_rst = 1'b0;
    cyc();
    #1;
    n_cmp++; if (b_grant !== 2'b01) begin n_bad++; $display("FAIL ar_first: got %b want 01", b_grant); end
    b_stall = 1'b0; b_m0_write = 1'b0; b_m1_read = 1'b0;
    cyc();
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; a_stall = 1'b0; b_stall = 1'b0;
    pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    a_m0_address = '0; a_m0_read = 1'b0; a_m0_write = 1'b0; a_m0_writedata = '0; a_m0_byteenable = '0;
    a_m1_address = '0; a_m1_read = 1'b0; a_m1_write = 1'b0; a_m1_writedata = '0; a_m1_byteenable = '0;
    b_m0_address = '0; b_m0_read = 1'b0; b_m0_write = 1'b0; b_m0_writedata = '0; b_m0_byteenable = '0;
    b_m1_address = '0; b_m1_read = 1'b0; b_m1_write = 1'b0; b_m1_writedata = '0; b_m1_byteenable = '0;
    repeat (2) cyc();
    b_rst = 1'b0;
    test_reset();
    test_fixed_priority();
    test_slave_stall();
    test_hold_limit();
    test_round_robin();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the Avalon memory-mapped bus.
- Shares the single RAM slave between the program loader/debug master (m0) and the CPU bus controller (m1).
- Sits between the masters and the RAM, and forwards the granted master's transfer combinationally.
- Provides fixed or round-robin priority, plus a hold limit so one master cannot starve the other.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byteenable width BE_W = DATA_W/8
ROUND_ROBIN, 0, 0 = m0 always wins ties; 1 = alternate on ties
MAX_HOLD, 4, completed transfers a master may chain while the other is requesting (≥1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
m0_address  in  ADDR_W  master 0 address
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_byteenable  in  BE_W  master 0 byte enables
m0_waitrequest  out  1  stall to master 0
m0_readdata  out  DATA_W  read data to master 0
m1_*  (same seven signals as m0, for master 1)
s_address  out  ADDR_W  to slave
s_read  out  1  to slave
s_write  out  1  to slave
s_writedata  out  DATA_W  to slave
s_byteenable  out  BE_W  to slave
s_waitrequest  in  1  from slave
s_readdata  in  DATA_W  from slave
grant  out  2  one-hot current owner; 00 = idle
busy  out  1  |grant

Behaviour:
- Definitions:
  - reqN = mN_read | mN_write.
  - A completion for master N is reqN & grant[N] & ~s_waitrequest in the same cycle. Read data is valid in that cycle; there is no readdatavalid.
- State: IDLE, GNT0, GNT1. Registers: hold_cnt (width clog2(MAX_HOLD)+1) and last (the last master granted).
- Reset (asynchronous, takes effect immediately):
  - State = IDLE, grant = 00, busy = 0, hold_cnt = 0, last = 1 (so m0 wins the first round-robin tie).
  - s_read = s_write = 0 at once, because the slave strobes decode from state.
  - A transfer in flight is aborted; its master sees waitrequest = 1.
- Forwarding (combinational from state):
  - In GNTn, all s_* outputs equal mn_*, and mn_waitrequest = s_waitrequest.
  - In IDLE, s_read = s_write = 0; s_address, s_writedata and s_byteenable = 0.
  - A non-granted master always sees waitrequest = 1.
  - s_readdata is broadcast to m0_readdata and m1_readdata unconditionally.
- IDLE transitions:
  - req0 only → GNT0. req1 only → GNT1.
  - Both requesting: ROUND_ROBIN=0 → GNT0; ROUND_ROBIN=1 → the master ≠ last.
  - Grant is registered, giving 1 cycle of arbitration latency. hold_cnt ← 0 and last ← the granted master.
- GNTn transitions, priority order:
  1. ~reqn (owner dropped its request): go to GNT(other) if req(other), else IDLE; hold_cnt ← 0.
  2. Completion with req(other) and hold_cnt+1 ≥ MAX_HOLD: go to GNT(other); hold_cnt ← 0; last ← other.
  3. Completion otherwise: stay in GNTn; hold_cnt ← hold_cnt+1 if req(other), else unchanged (saturating).
  4. No completion (slave stalling): stay; the grant is never removed mid-transfer.
- Back-to-back transfers by the owner have no dead cycle. A handover after a completion takes effect the next cycle, again with no dead cycle.
- The arbiter never changes s_address, s_writedata or s_byteenable while s_waitrequest = 1 and a request is pending.
- Simultaneous read & write from one master is passed through unmodified; the slave defines the behaviour.

Test Plan:
1. Reset held 2 cycles with m1_read=1 → grant=00, s_read=0, m1_waitrequest=1. Release → GNT1 on the 1st edge; s_address = m1_address; data 0x24020010 returned to m1 on the cycle s_waitrequest=0.
2. Fixed priority (ROUND_ROBIN=0): m0_write (addr 0x04, data 0x2403FFFB) and m1_read both asserted from IDLE → GNT0 first. After m0 completes and drops its request, GNT1; m1 reads back 0x2403FFFB.
3. Round-robin (ROUND_ROBIN=1): both masters request continuously, MAX_HOLD=1, slave has zero wait → grant sequence 01,10,01,10; each master sees one completion every 2 cycles.
4. Hold limit (MAX_HOLD=4): m0 streams writes to 0x04–0x1C while m1_read is pending → exactly 4 m0 completions, then GNT1. m1_waitrequest=1 throughout those 4 transfers.
5. Slave stall: s_waitrequest=1 for 5 cycles during an m1 read of 0x0C while m0 requests → grant stays 10; s_address stays 0x0C. Data 0x18600002 is delivered to m1, then grant moves to 01.
6. Asynchronous reset mid-transfer: assert reset between edges during an m0 write → s_write falls before the next clk edge; grant=00. After release with both masters requesting and ROUND_ROBIN=1, m0 is granted first.
